cfg_scan_loader: RTL and testbench
==================================

// Module: cfg_scan_loader
// PURPOSE
//  Upstream configuration stage of the Eyeriss core; replaces the preloaded config RAM.
//  Accepts NUM_WORDS config words from the host over a valid/ready stream.
//  Holds them in a register file and drives them as one flat bus into the core.
//  Gates the core start: start is forwarded only once a complete config is loaded and the core is idle.
// PARAMETERS
//  DATA_BITWIDTH  32  width of one config word
//  NUM_WORDS      31  config words per layer (word 0 = layer_HW ... word 30 = psum_col_id MSW)
// PORTS
//  i_clk             in   1                        clock, all state on rising edge
//  i_rst             in   1                        asynchronous, active-low reset
//  i_cfg_data        in   DATA_BITWIDTH            config word
//  i_cfg_valid       in   1                        i_cfg_data valid
//  o_cfg_ready       out  1                        loader accepts a word this cycle
//  i_cfg_clear       in   1                        discard loaded config, restart at word 0
//  i_host_start      in   1                        host request to run the core
//  o_core_start      out  1                        1-cycle start pulse to core (i_core_start)
//  i_core_done       in   1                        core done (level or pulse, from o_core_done)
//  o_cfg_loaded      out  1                        all NUM_WORDS words present
//  o_busy            out  1                        core running
//  o_start_rejected  out  1                        1-cycle pulse: i_host_start not honoured
//  o_config_flat     out  NUM_WORDS*DATA_BITWIDTH  word k at bits [k*DW +: DW]
// BEHAVIOUR
//  Reset (i_rst=0, async): state=LOAD, cnt=0, all words=0, done_q=0.
//   Outputs at reset: o_cfg_ready=1, o_core_start=0, o_cfg_loaded=0, o_busy=0, o_start_rejected=0, o_config_flat=0.
//  FSM has three states:
//   LOAD: o_cfg_ready=1. On valid&ready: word[cnt]<=data, cnt++.
//     When the accepted word is at cnt==NUM_WORDS-1, go to LOADED with cnt=0.
//   LOADED: o_cfg_ready=0, o_cfg_loaded=1. On i_host_start: o_core_start=1 next cycle, go to RUN.
//   RUN: o_busy=1, o_cfg_loaded=1, o_cfg_ready=0. Rising edge of i_core_done (i_core_done & ~done_q) -> LOADED.
//     done_q is a register of i_core_done, updated every cycle.
//  o_core_start: registered, exactly one cycle; latency 1 clock from sampled i_host_start.
//  Writes: i_cfg_valid is ignored unless o_cfg_ready; a word is never written outside LOAD.
//  i_cfg_clear in LOAD/LOADED: next cycle state=LOAD, cnt=0, all words=0.
//   Clear has priority over a same-cycle accept.
//  i_cfg_clear in RUN: ignored; config frozen while core runs.
//  i_host_start in LOAD or RUN: o_start_rejected pulses next cycle; no state change.
//  Simultaneous i_cfg_clear & i_host_start in LOADED: clear wins, start rejected (pulse).
//  i_host_start held high across cycles in LOADED: only the first sampled cycle starts the core.
//   Later cycles in RUN produce rejected pulses.
//  i_core_done high already on entry to RUN (stale level from previous run): no edge, stays RUN.
//  i_core_done edge outside RUN: ignored.
//  Reset mid-load or mid-run: config lost and FSM back to LOAD. Core is reset by the same i_rst.
//  Width rules:
//   cnt width = clogb2(NUM_WORDS-1); never exceeds NUM_WORDS-1; no wrap past the last word.
//   o_config_flat is driven directly from the registers: no extra latency, stable outside LOAD.
// STRUCTURE
//  Shared package eyeriss_cfg_pkg:
//   NUM_CFG_WORDS=31.
//   Word-index constants CFG_HW=0, CFG_U=1, CFG_PAD=2, CFG_M=3, CFG_N=4, CFG_E=5, CFG_P=6, CFG_Q=7, CFG_R=8,
//    CFG_S=9, CFG_T=10, CFG_IFMAP_ROW_ID=11, CFG_WGHT_ROW_ID=12, CFG_PSUM_ROW_ID=13,
//    CFG_IFMAP_COL_ID=14..20, CFG_WGHT_COL_ID=21..25, CFG_PSUM_COL_ID=26..30.
//   FSM state encoding ST_LOAD/ST_LOADED/ST_RUN.
//  No sub-module is needed: a single FSM plus the register file. The done edge detect is inline.
// TESTING
//  1. Reset, then stream 31 words 0x100+k with valid=1 continuously.
//     -> 31 accepts; o_cfg_loaded=1 after word 30; o_cfg_ready=0; word k = 0x100+k in o_config_flat.
//  2. Loaded; pulse i_host_start.
//     -> o_core_start=1 for exactly 1 cycle, next clock; o_busy=1.
//     -> Drive i_core_done high 50 cycles later: o_busy=0 next cycle.
//  3. Load 10 words, assert i_cfg_clear with valid=1.
//     -> cnt=0, o_config_flat=0, word not written; then a full 31-word reload succeeds.
//  4. i_host_start during LOAD and during RUN.
//     -> o_start_rejected pulse each time, no o_core_start.
//     -> i_cfg_clear in RUN leaves o_config_flat unchanged.
//  5. Leave i_core_done high from run 1, restart.
//     -> stays RUN until done falls and rises again; clear+start same cycle in LOADED -> LOAD, rejected=1.
//  6. Assert i_rst low mid-run at an arbitrary clock phase.
//     -> all outputs at reset values immediately (async); o_cfg_ready=1 after release.

Source files
------------

// File: rtl/eyeriss_cfg_pkg.sv
// rtl/eyeriss_cfg_pkg.sv - shared Eyeriss config word map, loader states and width helper
package eyeriss_cfg_pkg;

  localparam int NUM_CFG_WORDS = 31;

  localparam int CFG_HW                = 0;
  localparam int CFG_U                 = 1;
  localparam int CFG_PAD               = 2;
  localparam int CFG_M                 = 3;
  localparam int CFG_N                 = 4;
  localparam int CFG_E                 = 5;
  localparam int CFG_P                 = 6;
  localparam int CFG_Q                 = 7;
  localparam int CFG_R                 = 8;
  localparam int CFG_S                 = 9;
  localparam int CFG_T                 = 10;
  localparam int CFG_IFMAP_ROW_ID      = 11;
  localparam int CFG_WGHT_ROW_ID       = 12;
  localparam int CFG_PSUM_ROW_ID       = 13;
  localparam int CFG_IFMAP_COL_ID      = 14;
  localparam int CFG_IFMAP_COL_ID_LAST = 20;
  localparam int CFG_WGHT_COL_ID       = 21;
  localparam int CFG_WGHT_COL_ID_LAST  = 25;
  localparam int CFG_PSUM_COL_ID       = 26;
  localparam int CFG_PSUM_COL_ID_LAST  = 30;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2
  } cfg_state_t;

  // Bits needed to hold value; never less than one so a counter always exists.
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cfg_scan_loader.sv
// rtl/cfg_scan_loader.sv - streams layer config words into a register file and gates core start
module cfg_scan_loader
  import eyeriss_cfg_pkg::*;
#(
  parameter int DATA_BITWIDTH = 32,
  parameter int NUM_WORDS     = NUM_CFG_WORDS
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [DATA_BITWIDTH-1:0]           i_cfg_data,
  input  logic                               i_cfg_valid,
  output logic                               o_cfg_ready,
  input  logic                               i_cfg_clear,
  input  logic                               i_host_start,
  output logic                               o_core_start,
  input  logic                               i_core_done,
  output logic                               o_cfg_loaded,
  output logic                               o_busy,
  output logic                               o_start_rejected,
  output logic [NUM_WORDS*DATA_BITWIDTH-1:0] o_config_flat
);

  localparam int              CNT_W    = clogb2(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  cfg_state_t               state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_BITWIDTH-1:0] words [NUM_WORDS];
  logic                     done_q;
  logic                     core_start_q;
  logic                     start_rej_q;

  logic in_load, in_loaded, in_run;
  logic clear_en, accept, start_ok, done_rise;

  assign in_load   = (state == ST_LOAD);
  assign in_loaded = (state == ST_LOADED);
  assign in_run    = (state == ST_RUN);

  // Config is frozen while the core runs, so clear only acts outside RUN.
  assign clear_en  = i_cfg_clear && !in_run;
  assign accept    = in_load && i_cfg_valid && !clear_en;
  assign start_ok  = in_loaded && i_host_start && !clear_en;
  assign done_rise = i_core_done && !done_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (clear_en)                        state_nxt = ST_LOAD;
        else if (accept && cnt == LAST_IDX)  state_nxt = ST_LOADED;
      end
      ST_LOADED: begin
        if (clear_en)          state_nxt = ST_LOAD;
        else if (i_host_start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (done_rise) state_nxt = ST_LOADED;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt          <= '0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      start_rej_q  <= 1'b0;
    end else begin
      done_q       <= i_core_done;
      core_start_q <= start_ok;
      start_rej_q  <= i_host_start && !start_ok;
      if (clear_en)
        cnt <= '0;
      else if (accept)
        cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int k = 0; k < NUM_WORDS; k++) words[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (clear_en)
          words[k] <= '0;
        else if (accept && cnt == CNT_W'(k))
          words[k] <= i_cfg_data;
      end
    end
  end

  always_comb begin
    o_config_flat = '0;
    for (int k = 0; k < NUM_WORDS; k++)
      o_config_flat[k*DATA_BITWIDTH +: DATA_BITWIDTH] = words[k];
  end

  assign o_cfg_ready      = in_load;
  assign o_cfg_loaded     = !in_load;
  assign o_busy           = in_run;
  assign o_core_start     = core_start_q;
  assign o_start_rejected = start_rej_q;

endmodule

// File: tb/tb_cfg_scan_loader.sv
// tb/tb_cfg_scan_loader.sv - self-checking bench for cfg_scan_loader
module tb_cfg_scan_loader;

  localparam int DW = 32;
  localparam int NW = 31;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic              cfg_clear = 1'b0;
  logic              host_start = 1'b0;
  logic              core_start;
  logic              core_done = 1'b0;
  logic              cfg_loaded;
  logic              busy;
  logic              start_rejected;
  logic [NW*DW-1:0]  config_flat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cfg_scan_loader #(.DATA_BITWIDTH(DW), .NUM_WORDS(NW)) dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_cfg_data       (cfg_data),
    .i_cfg_valid      (cfg_valid),
    .o_cfg_ready      (cfg_ready),
    .i_cfg_clear      (cfg_clear),
    .i_host_start     (host_start),
    .o_core_start     (core_start),
    .i_core_done      (core_done),
    .o_cfg_loaded     (cfg_loaded),
    .o_busy           (busy),
    .o_start_rejected (start_rejected),
    .o_config_flat    (config_flat)
  );

  // Reference model: a word list with a fill count, plus "full" and "running" flags.
  logic [DW-1:0] m_words [NW];
  int            m_fill;
  bit            m_full, m_running, m_done_prev, m_start, m_rej;

  task automatic model_reset();
    for (int k = 0; k < NW; k++) m_words[k] = '0;
    m_fill = 0; m_full = 0; m_running = 0; m_done_prev = 0; m_start = 0; m_rej = 0;
  endtask

  task automatic model_step();
    bit can_start, rise;
    can_start   = m_full && !m_running && host_start && !cfg_clear;
    rise        = core_done && !m_done_prev;
    m_start     = can_start;
    m_rej       = host_start && !can_start;
    m_done_prev = core_done;
    if (cfg_clear && !m_running) begin
      for (int k = 0; k < NW; k++) m_words[k] = '0;
      m_fill = 0; m_full = 0;
    end else if (!m_full && cfg_valid) begin
      m_words[m_fill] = cfg_data;
      m_fill++;
      if (m_fill == NW) begin m_full = 1; m_fill = 0; end
    end else if (can_start) begin
      m_running = 1;
    end else if (m_running && rise) begin
      m_running = 0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_flat(input string name, input logic [NW*DW-1:0] exp);
    n_tests++;
    if (config_flat !== exp) begin
      n_fail++;
      for (int k = 0; k < NW; k++) begin
        if (config_flat[k*DW +: DW] !== exp[k*DW +: DW]) begin
          $display("FAIL %s: word %0d got %0h expected %0h", name, k,
                   config_flat[k*DW +: DW], exp[k*DW +: DW]);
          break;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [NW*DW-1:0] exp;
    for (int k = 0; k < NW; k++) exp[k*DW +: DW] = m_words[k];
    chk({tag, ".ready"},  {63'd0, cfg_ready},      {63'd0, !m_full});
    chk({tag, ".loaded"}, {63'd0, cfg_loaded},     {63'd0, m_full});
    chk({tag, ".busy"},   {63'd0, busy},           {63'd0, m_running});
    chk({tag, ".start"},  {63'd0, core_start},     {63'd0, m_start});
    chk({tag, ".rej"},    {63'd0, start_rejected}, {63'd0, m_rej});
    chk_flat({tag, ".flat"}, exp);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; cfg_clear = 0; host_start = 0; cfg_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ready"},  {63'd0, cfg_ready},      64'd1);
    chk({tag, ".loaded"}, {63'd0, cfg_loaded},     64'd0);
    chk({tag, ".busy"},   {63'd0, busy},           64'd0);
    chk({tag, ".start"},  {63'd0, core_start},     64'd0);
    chk({tag, ".rej"},    {63'd0, start_rejected}, 64'd0);
    chk_flat({tag, ".flat"}, '0);
  endtask

  task automatic load_all(input logic [DW-1:0] base, input string tag);
    int acc;
    acc = 0;
    for (int k = 0; k < NW; k++) begin
      cfg_valid = 1; cfg_data = base + DW'(k);
      if (cfg_ready) acc++;
      tick(tag);
      if (k < NW - 1) chk({tag, ".not_yet_loaded"}, {63'd0, cfg_loaded}, 64'd0);
    end
    cfg_valid = 0;
    chk({tag, ".accepts"}, 64'(acc), 64'(NW));
    chk({tag, ".loaded"},  {63'd0, cfg_loaded}, 64'd1);
    chk({tag, ".ready"},   {63'd0, cfg_ready},  64'd0);
    for (int k = 0; k < NW; k++)
      chk({tag, ".word"}, {32'd0, config_flat[k*DW +: DW]}, {32'd0, base + DW'(k)});
  endtask

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          clear, host, done;
    logic          e_ready, e_loaded, e_busy, e_start, e_rej;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [NW*DW-1:0] saved_flat;

    //            valid data          clr host done  rdy ld  busy st  rej
    tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'hBAD0,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 32'h5A5A,     1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    tick("post_reset");

    // Full load of 0x100+k.
    load_all(32'h100, "load1");

    // Start, run for a while, then done rises.
    host_start = 1;
    tick("start");
    chk("start.pulse", {63'd0, core_start}, 64'd1);
    chk("start.busy",  {63'd0, busy},       64'd1);
    host_start = 0;
    tick("start2");
    chk("start.one_cycle", {63'd0, core_start}, 64'd0);
    repeat (48) tick("run");
    core_done = 1;
    tick("done");
    chk("done.busy_low", {63'd0, busy}, 64'd0);

    // Vector table from LOADED with a stale high done level.
    saved_flat = config_flat;
    for (int i = 0; i < 12; i++) begin
      cfg_valid = tbl[i].valid; cfg_data = tbl[i].data; cfg_clear = tbl[i].clear;
      host_start = tbl[i].host; core_done = tbl[i].done;
      tick("tbl");
      chk($sformatf("tbl%0d.ready", i),  {63'd0, cfg_ready},      {63'd0, tbl[i].e_ready});
      chk($sformatf("tbl%0d.loaded", i), {63'd0, cfg_loaded},     {63'd0, tbl[i].e_loaded});
      chk($sformatf("tbl%0d.busy", i),   {63'd0, busy},           {63'd0, tbl[i].e_busy});
      chk($sformatf("tbl%0d.start", i),  {63'd0, core_start},     {63'd0, tbl[i].e_start});
      chk($sformatf("tbl%0d.rej", i),    {63'd0, start_rejected}, {63'd0, tbl[i].e_rej});
      if (i == 3) chk_flat("run_clear_frozen", saved_flat);
    end
    idle_inputs(); core_done = 0;

    // Clear mid-load with a valid word present: clear wins, then full reload.
    cfg_clear = 1;
    tick("clear0");
    cfg_clear = 0;
    for (int k = 0; k < 10; k++) begin
      cfg_valid = 1; cfg_data = 32'hA000 + DW'(k);
      tick("part");
    end
    cfg_valid = 1; cfg_clear = 1; cfg_data = 32'hDEAD;
    tick("clear_mid");
    chk_flat("clear_mid.flat_zero", '0);
    chk("clear_mid.ready", {63'd0, cfg_ready}, 64'd1);
    idle_inputs();
    load_all(32'h200, "reload");

    // Async reset mid-run, off the clock edge.
    host_start = 1;
    tick("run2");
    host_start = 0;
    tick("run2b");
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    tick("after_reset");
    chk("after_reset.ready", {63'd0, cfg_ready}, 64'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      cfg_valid  = ($urandom_range(0, 9) < 7);
      cfg_data   = $urandom;
      cfg_clear  = ($urandom_range(0, 99) == 0);
      host_start = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 99) < 15) core_done = ~core_done;
      tick("rand");
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
